// File: rtl/mac_stream_cell_pkg.sv
// Shared types and helpers for the streaming MAC cell family.
// sat_narrow clamps only when saturation is requested; the caller keeps the low DATA_W bits.
package cell_package;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        PENDING
    } cell_state_e;

    localparam int unsigned NARROW_W = 64;

    function automatic logic signed [NARROW_W-1:0] sat_narrow(
        input logic signed [NARROW_W-1:0] value,
        input int unsigned                dataW,
        input logic                       saturate
    );
        logic signed [NARROW_W-1:0] hi;
        logic signed [NARROW_W-1:0] lo;
        hi = $signed((64'd1 << (dataW - 1)) - 64'd1);
        lo = -hi - 64'sd1;
        if (saturate && (value > hi)) return hi;
        if (saturate && (value < lo)) return lo;
        return value;
    endfunction

endpackage

// File: rtl/mac_stream_cell_weight_bank.sv
// Runtime-loadable weight register bank with combinational read.
// Out-of-range reads return zero and raise rdErr.
module mac_weight_bank
    import cell_package::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned N_INPUTS = 3,
    parameter int unsigned IDX_W    = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wrEn,
    input  logic [IDX_W-1:0]  wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [IDX_W-1:0]  rdAddr,
    output logic [DATA_W-1:0] rdData,
    output logic              rdErr
);

    logic [DATA_W-1:0] weights [N_INPUTS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_INPUTS; i++) weights[i] <= '0;
        end else if (wrEn) begin
            for (int unsigned i = 0; i < N_INPUTS; i++) begin
                if (wrAddr == IDX_W'(i)) weights[i] <= wrData;
            end
        end
    end

    always_comb begin
        rdData = '0;
        for (int unsigned i = 0; i < N_INPUTS; i++) begin
            if (rdAddr == IDX_W'(i)) rdData = weights[i];
        end
    end

    assign rdErr = (32'(rdAddr) >= N_INPUTS);

endmodule

// File: rtl/mac_stream_cell.sv
// Handshaked MAC cell: accumulates a dot product and forwards beats along a cell chain.
// Define CELL_SATURATE_EN for saturating accumulation and clamped result narrowing.
module mac_stream_cell
    import cell_package::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ACC_W        = 24,
    parameter int unsigned N_INPUTS     = 3,
    parameter int unsigned IDX_W        = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
    parameter int unsigned OUT_SHIFT    = 0,
    parameter bit          IS_LAST_CELL = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_first,
    input  logic              in_last,
    input  logic              in_result,
    input  logic [IDX_W-1:0]  in_windex,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_first,
    output logic              out_last,
    output logic              out_result,
    output logic [IDX_W-1:0]  out_windex,
    input  logic              w_load_en,
    input  logic [IDX_W-1:0]  w_load_addr,
    input  logic [DATA_W-1:0] w_load_data,
    output logic              w_load_err,
    output logic              idx_err
);

`ifdef CELL_SATURATE_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    cell_state_e state;
    logic signed [ACC_W-1:0] acc;
    logic xfer;

    logic outFree, accept, dataAccept, resultAccept, emitOwn, wrEn, lastTaken;
    logic [DATA_W-1:0] weight;
    logic idxBad;
    logic signed [2*DATA_W-1:0] dataExt, weightExt, product;
    logic signed [ACC_W-1:0] productExt, accSum, shifted;
    logic signed [ACC_W:0] sumWide;
    logic [DATA_W-1:0] ownData;

    mac_weight_bank #(
        .DATA_W  (DATA_W),
        .N_INPUTS(N_INPUTS),
        .IDX_W   (IDX_W)
    ) weightBank (
        .clock (clock),
        .reset (reset),
        .wrEn  (wrEn),
        .wrAddr(w_load_addr),
        .wrData(w_load_data),
        .rdAddr(in_windex),
        .rdData(weight),
        .rdErr (idxBad)
    );

    assign outFree      = !out_valid || out_ready;
    assign in_ready     = outFree && !((state == PENDING) && !in_result);
    assign accept       = in_valid && in_ready;
    assign dataAccept   = accept && !in_result;
    assign resultAccept = accept && in_result;
    assign emitOwn      = (state == PENDING) && outFree && !accept;
    assign wrEn         = w_load_en && (state == IDLE) && !dataAccept;
    assign lastTaken    = dataAccept && in_last && (in_first || (state == ACCUM));

    // Bank returns zero for out-of-range indices, so the product is already zero there.
    always_comb begin
        dataExt    = (2*DATA_W)'($signed(in_data));
        weightExt  = (2*DATA_W)'($signed(weight));
        product    = dataExt * weightExt;
        productExt = ACC_W'(product);
        sumWide    = (ACC_W+1)'(acc) + (ACC_W+1)'(productExt);
        accSum     = sumWide[ACC_W-1:0];
        if (SAT_EN && (sumWide[ACC_W] != sumWide[ACC_W-1])) begin
            accSum = sumWide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        shifted = acc >>> OUT_SHIFT;
        ownData = DATA_W'(sat_narrow(NARROW_W'(shifted), DATA_W, SAT_EN));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            xfer       <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            out_result <= 1'b0;
            out_windex <= '0;
            w_load_err <= 1'b0;
            idx_err    <= 1'b0;
        end else begin
            w_load_err <= w_load_en && !wrEn;
            if (dataAccept && idxBad) idx_err <= 1'b1;

            if (dataAccept) begin
                if (in_first) begin
                    acc   <= productExt;
                    state <= in_last ? PENDING : ACCUM;
                end else if (state == ACCUM) begin
                    acc <= accSum;
                    if (in_last) state <= PENDING;
                end
                if (IS_LAST_CELL && lastTaken) xfer <= 1'b1;
            end

            if (outFree) begin
                out_valid <= 1'b0;
                if (resultAccept) begin
                    out_valid  <= 1'b1;
                    out_data   <= in_data;
                    out_windex <= in_windex;
                    if (IS_LAST_CELL) begin
                        out_first  <= xfer;
                        out_last   <= 1'b0;
                        out_result <= 1'b0;
                        xfer       <= 1'b0;
                    end else begin
                        out_first  <= in_first;
                        out_last   <= in_last;
                        out_result <= 1'b1;
                    end
                end else if (dataAccept) begin
                    if (!IS_LAST_CELL) begin
                        out_valid  <= 1'b1;
                        out_data   <= in_data;
                        out_windex <= in_windex;
                        out_first  <= in_first;
                        out_last   <= in_last;
                        out_result <= 1'b0;
                    end
                end else if (emitOwn) begin
                    out_valid  <= 1'b1;
                    out_data   <= ownData;
                    out_windex <= '0;
                    out_result <= !IS_LAST_CELL;
                    out_first  <= IS_LAST_CELL && xfer;
                    out_last   <= IS_LAST_CELL;
                    xfer       <= 1'b0;
                    state      <= IDLE;
                end
            end
        end
    end

endmodule
